// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory initiator.
// Also holds the request legality rule so the writeback side can reuse it.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StDone
  } state_e;

  function automatic logic req_illegal(logic [1:0] size, logic [31:0] addr,
                                       int unsigned mem_bytes, logic check_align);
    logic misaligned;
    misaligned = ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    return (size == 2'b11) || (addr >= mem_bytes) || (check_align && misaligned);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, response and data-RAM port bundle for mem_access_ctrl.
// slave is the controller's view; master is the pipeline/RAM side.
interface mem_access_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        ram_enable;
  logic        ram_read_write;
  logic [1:0]  ram_size;
  logic [31:0] ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport slave (
    input  req_valid, req_load, req_size, req_signed, req_addr, req_wdata, ram_data_out,
    output req_ready, ram_enable, ram_read_write, ram_size, ram_address, ram_data_in,
    output rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport master (
    output req_valid, req_load, req_size, req_signed, req_addr, req_wdata, ram_data_out,
    input  req_ready, ram_enable, ram_read_write, ram_size, ram_address, ram_data_in,
    input  rsp_valid, rsp_rdata, rsp_err, stall
  );

endinterface

// File: rtl/load_extender.sv
// Combinational load-data extender: selects byte/halfword/word from right-justified
// RAM data and zero- or sign-extends it. Shared with the writeback mux.
module load_extender
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (size)
      SZ_BYTE: data_out = {{24{sign_ext & data_in[7]}}, data_in[7:0]};
      SZ_HALF: data_out = {{16{sign_ext & data_in[15]}}, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: drives the level-sensitive data RAM with a setup/strobe/release
// sequence and returns extended load data plus an error flag toward MEM/WB.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 256,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);

  state_e      state_q;
  logic        signed_q;
  logic        accept;
  logic        illegal;
  logic [31:0] ext_data;

  assign accept  = bus.req_valid && (state_q == StIdle);
  assign illegal = req_illegal(bus.req_size, bus.req_addr, MEM_BYTES, CHECK_ALIGN);

  // Only these two decode state directly; everything else is registered.
  assign bus.req_ready = (state_q == StIdle);
  assign bus.stall     = (state_q == StSetup) || (state_q == StStrobe) ||
                         ((state_q == StIdle) && bus.req_valid);

  load_extender u_load_extender (
    .size     (bus.ram_size),
    .sign_ext (signed_q),
    .data_in  (bus.ram_data_out),
    .data_out (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      signed_q           <= 1'b0;
      bus.ram_enable     <= 1'b0;
      bus.ram_read_write <= RW_READ;
      bus.ram_size       <= SZ_BYTE;
      bus.ram_address    <= '0;
      bus.ram_data_in    <= '0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.rsp_err        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            signed_q <= bus.req_signed;
            if (illegal) begin
              state_q       <= StDone;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              // The RAM-facing registers double as the latched request, so the
              // address/size/data are stable a full cycle before Enable rises.
              state_q            <= StSetup;
              bus.ram_read_write <= bus.req_load ? RW_READ : RW_WRITE;
              bus.ram_size       <= bus.req_size;
              bus.ram_address    <= bus.req_addr;
              bus.ram_data_in    <= bus.req_wdata;
            end
          end
        end
        StSetup: begin
          state_q        <= StStrobe;
          bus.ram_enable <= 1'b1;
        end
        StStrobe: begin
          state_q        <= StDone;
          bus.ram_enable <= 1'b0;
          bus.rsp_valid  <= 1'b1;
          bus.rsp_err    <= 1'b0;
          bus.rsp_rdata  <= (bus.ram_read_write == RW_READ) ? ext_data : '0;
        end
        StDone: begin
          state_q       <= StIdle;
          bus.rsp_valid <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-array RAM model on the RAM port and a
// transaction-level reference memory that predicts every response.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .MEM_BYTES   (256),
    .CHECK_ALIGN (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  ram_mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  ram_a;
  logic [31:0] ram_dout;
  bit          preloaded = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned en_rises = 0;
  int unsigned rsp_pulses = 0;
  bit          prev_keep = 1'b0;

  function automatic logic [7:0] pat(int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // RAM model: big-endian, right-justified, write committed while Enable is high.
  assign ram_a = bus.ram_address[7:0];

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= pat(i);
      preloaded <= 1'b1;
    end else if (bus.ram_enable && bus.ram_read_write == RW_WRITE) begin
      case (bus.ram_size)
        SZ_BYTE: ram_mem[ram_a] <= bus.ram_data_in[7:0];
        SZ_HALF: begin
          ram_mem[ram_a]        <= bus.ram_data_in[15:8];
          ram_mem[ram_a + 8'd1] <= bus.ram_data_in[7:0];
        end
        default: begin
          ram_mem[ram_a]        <= bus.ram_data_in[31:24];
          ram_mem[ram_a + 8'd1] <= bus.ram_data_in[23:16];
          ram_mem[ram_a + 8'd2] <= bus.ram_data_in[15:8];
          ram_mem[ram_a + 8'd3] <= bus.ram_data_in[7:0];
        end
      endcase
    end
  end

  always_comb begin
    ram_dout = '0;
    if (bus.ram_enable && bus.ram_read_write == RW_READ) begin
      case (bus.ram_size)
        SZ_BYTE: ram_dout = {24'h0, ram_mem[ram_a]};
        SZ_HALF: ram_dout = {16'h0, ram_mem[ram_a], ram_mem[ram_a + 8'd1]};
        default: ram_dout = {ram_mem[ram_a], ram_mem[ram_a + 8'd1],
                             ram_mem[ram_a + 8'd2], ram_mem[ram_a + 8'd3]};
      endcase
    end
  end
  assign bus.ram_data_out = ram_dout;

  always @(posedge bus.ram_enable) en_rises <= en_rises + 1;
  always @(posedge clk) if (bus.rsp_valid) rsp_pulses <= rsp_pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit ref_illegal(logic [1:0] size, logic [31:0] addr);
    return (size == 2'd3) || (addr >= 32'd256) ||
           (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  task automatic ref_access(input bit load, input logic [1:0] size, input bit sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output bit err);
    int          nbytes;
    longint unsigned v;
    rdata = '0;
    err   = ref_illegal(size, addr);
    if (err) return;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (!load) begin
      for (int i = 0; i < nbytes; i++)
        ref_mem[int'(addr) + i] = 8'(wdata >> (8 * (nbytes - 1 - i)));
    end else begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v * 256 + longint'(ref_mem[int'(addr) + i]);
      if (sgn && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1)))
        v = v + 64'h1_0000_0000 - (64'd1 << (8 * nbytes));
      rdata = 32'(v);
    end
  endtask

  // Called at a negedge; returns at the DONE negedge (keep=1) or the following IDLE one.
  task automatic do_access(input bit load, input logic [1:0] size, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit keep, output logic [31:0] rdata);
    logic [31:0] exp_rdata;
    bit          exp_err;
    int unsigned rise0;
    int          waited;
    logic        exp_ready;
    ref_access(load, size, sgn, addr, wdata, exp_rdata, exp_err);
    bus.req_valid  = 1'b1;
    bus.req_load   = load;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    waited = 0;
    forever begin
      #1;
      exp_ready = !(waited == 0 && prev_keep);
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("stall_pre", 32'(bus.stall), 32'(exp_ready));
      if (bus.req_ready || waited >= 3) break;
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 32'(waited), prev_keep ? 32'd1 : 32'd0);
    rise0 = en_rises;
    @(posedge clk);
    @(negedge clk);
    if (!exp_err) begin
      check("setup_en", 32'(bus.ram_enable), 32'd0);
      check("setup_addr", bus.ram_address, addr);
      check("setup_size", 32'(bus.ram_size), 32'(size));
      check("setup_rw", 32'(bus.ram_read_write), load ? 32'd0 : 32'd1);
      check("setup_din", bus.ram_data_in, wdata);
      check("setup_rsp", 32'(bus.rsp_valid), 32'd0);
      check("setup_stall", 32'(bus.stall), 32'd1);
      @(negedge clk);
      check("strobe_en", 32'(bus.ram_enable), 32'd1);
      check("strobe_addr", bus.ram_address, addr);
      check("strobe_rw", 32'(bus.ram_read_write), load ? 32'd0 : 32'd1);
      check("strobe_rsp", 32'(bus.rsp_valid), 32'd0);
      check("strobe_stall", 32'(bus.stall), 32'd1);
      @(negedge clk);
    end
    check("done_valid", 32'(bus.rsp_valid), 32'd1);
    check("done_err", 32'(bus.rsp_err), 32'(exp_err));
    check("done_rdata", bus.rsp_rdata, exp_rdata);
    check("done_en", 32'(bus.ram_enable), 32'd0);
    check("done_stall", 32'(bus.stall), 32'd0);
    check("en_rises", en_rises - rise0, exp_err ? 32'd0 : 32'd1);
    rdata     = bus.rsp_rdata;
    prev_keep = keep;
    if (!keep) begin
      bus.req_valid = 1'b0;
      @(negedge clk);
      #1;
      check("idle_stall", 32'(bus.stall), 32'd0);
      check("idle_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int unsigned p0;
    rst_n          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_load   = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(bus.ram_enable), 32'd0);
    check("rst_rw", 32'(bus.ram_read_write), 32'd0);
    check("rst_size", 32'(bus.ram_size), 32'd0);
    check("rst_addr", bus.ram_address, 32'd0);
    check("rst_din", bus.ram_data_in, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;

    do_access(1'b0, SZ_WORD, 1'b0, 32'd8, 32'hDEADBEEF, 1'b0, r);
    do_access(1'b1, SZ_WORD, 1'b0, 32'd8, 32'h0, 1'b0, r);
    check("ld_word_8", r, 32'hDEADBEEF);
    do_access(1'b1, SZ_BYTE, 1'b1, 32'd9, 32'h0, 1'b0, r);
    check("ld_byte_s", r, 32'hFFFFFFAD);
    do_access(1'b1, SZ_BYTE, 1'b0, 32'd9, 32'h0, 1'b0, r);
    check("ld_byte_u", r, 32'h000000AD);
    do_access(1'b1, SZ_HALF, 1'b1, 32'd10, 32'h0, 1'b0, r);
    check("ld_half_s", r, 32'hFFFFBEEF);
    do_access(1'b1, SZ_HALF, 1'b0, 32'd10, 32'h0, 1'b0, r);
    check("ld_half_u", r, 32'h0000BEEF);
    do_access(1'b1, SZ_WORD, 1'b0, 32'd6, 32'h0, 1'b0, r);
    do_access(1'b0, SZ_BYTE, 1'b0, 32'd256, 32'h55, 1'b0, r);
    do_access(1'b1, 2'b11, 1'b0, 32'd0, 32'h0, 1'b0, r);

    // Back-to-back with req_valid held high throughout.
    do_access(1'b0, SZ_HALF, 1'b0, 32'd40, 32'h0000_8123, 1'b1, r);
    do_access(1'b1, SZ_HALF, 1'b1, 32'd40, 32'h0, 1'b1, r);
    do_access(1'b1, SZ_WORD, 1'b0, 32'd42, 32'h0, 1'b1, r);
    do_access(1'b1, SZ_BYTE, 1'b1, 32'd41, 32'h0, 1'b0, r);

    // Reset during STROBE of a store abandons it.
    bus.req_valid = 1'b1;
    bus.req_load  = 1'b0;
    bus.req_size  = SZ_WORD;
    bus.req_addr  = 32'd20;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_strobe", 32'(bus.ram_enable), 32'd1);
    p0 = rsp_pulses;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("rst_mid_en", 32'(bus.ram_enable), 32'd0);
    check("rst_mid_rsp", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_addr", bus.ram_address, 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_rsp", rsp_pulses - p0, 32'd0);
    prev_keep = 1'b0;
    do_access(1'b1, SZ_WORD, 1'b0, 32'd20, 32'h0, 1'b0, r);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      sz  = 2'($urandom_range(0, 3));
      if (sel < 8) a = 32'($urandom_range(0, 255));
      else if (sel == 8) a = 32'($urandom_range(256, 270));
      else a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_HALF) a[0] = 1'b0;
        if (sz == SZ_WORD) a[1:0] = 2'b00;
      end
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                (n != 149) && ($urandom_range(0, 1) == 1), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
